// File: rtl/l1cache_ddr_adapter.sv
// Splits one L1 line fill/writeback into a word-wide burst on a ready/valid memory port and assembles fill beats.
// Latency req->done = beats+3 cycles minimum; stalls on mem_cmd_ready/mem_wdata_ready, read beats take no backpressure.
module l1cache_ddr_adapter #(
  parameter int line_size_bits = 256,
  parameter int word_size_bits = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               l1cache_ddr_addr,
  input  logic [line_size_bits-1:0] l1cache_ddr_wdata,
  input  logic                      ctl_ddr_read_req,
  input  logic                      ctl_ddr_write_req,
  output logic [line_size_bits-1:0] ddr_l1cache_rdata,
  output logic                      ddr_ctl_done,
  output logic                      mem_cmd_v,
  output logic                      mem_cmd_write,
  output logic [31:0]               mem_cmd_addr,
  input  logic                      mem_cmd_ready,
  output logic [word_size_bits-1:0] mem_wdata,
  output logic                      mem_wdata_v,
  input  logic                      mem_wdata_ready,
  input  logic [word_size_bits-1:0] mem_rdata,
  input  logic                      mem_rdata_v
);

  localparam int beats       = line_size_bits / word_size_bits;
  localparam int offset_bits = $clog2(line_size_bits / 8);
  localparam int cnt_bits    = $clog2(beats);
  localparam logic [31:0] align_mask = ~((32'd1 << offset_bits) - 32'd1);
  localparam logic [cnt_bits-1:0] last_cnt = cnt_bits'(beats - 1);

  typedef enum logic [2:0] {IDLE, CMD, WBEAT, RBEAT, DONE} state_t;

  state_t                                   state_q, state_d;
  logic [cnt_bits-1:0]                      cnt_q, cnt_d;
  logic [31:0]                              addr_q;
  logic                                     write_q;
  logic [beats-1:0][word_size_bits-1:0]     wbuf_q;
  logic [beats-1:0][word_size_bits-1:0]     rbuf_q;
  logic                                     rbeat_fire;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_cmd_v    = 1'b0;
    mem_wdata_v  = 1'b0;
    ddr_ctl_done = 1'b0;
    rbeat_fire   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctl_ddr_write_req || ctl_ddr_read_req) state_d = CMD;
      end
      CMD: begin
        mem_cmd_v = 1'b1;
        if (mem_cmd_ready) begin
          cnt_d   = '0;
          state_d = write_q ? WBEAT : RBEAT;
        end
      end
      WBEAT: begin
        mem_wdata_v = 1'b1;
        if (mem_wdata_ready) begin
          if (cnt_q == last_cnt) state_d = DONE;
          else                   cnt_d   = cnt_q + 1'b1;
        end
      end
      RBEAT: begin
        if (mem_rdata_v) begin
          rbeat_fire = 1'b1;
          if (cnt_q == last_cnt) state_d = DONE;
          else                   cnt_d   = cnt_q + 1'b1;
        end
      end
      DONE: begin
        ddr_ctl_done = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wbuf_q  <= '0;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Write wins a simultaneous request; a still-pending read is taken on a later IDLE visit.
      if (state_q == IDLE) begin
        if (ctl_ddr_write_req) begin
          addr_q  <= l1cache_ddr_addr & align_mask;
          write_q <= 1'b1;
          wbuf_q  <= l1cache_ddr_wdata;
        end else if (ctl_ddr_read_req) begin
          addr_q  <= l1cache_ddr_addr & align_mask;
          write_q <= 1'b0;
        end
      end
      if (rbeat_fire) rbuf_q[cnt_q] <= mem_rdata;
    end
  end

  assign mem_cmd_addr      = addr_q;
  assign mem_cmd_write     = write_q;
  assign mem_wdata         = (state_q == WBEAT) ? wbuf_q[cnt_q] : '0;
  assign ddr_l1cache_rdata = rbuf_q;

endmodule
